cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit simple CPU.
- It is the initiator that drives the ALU: it issues DataA, DataB, ALUSel and WriteCZ, then consumes DataOut, CF and ZF.
- Owns the PC, the instruction register, a 4x8 register file and latched C/Z flags.
- Reads an external asynchronous instruction ROM.

Parameters:
- WIDTH_DATA_LENGTH, 8, datapath and instruction byte width.
- WIDTH_ALUSEL_LENGTH, 4, ALU operation select width.
- WIDTH_ADDR_LENGTH, 8, instruction address width (PC).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IAddr  out  WIDTH_ADDR_LENGTH  instruction ROM address, equal to PC.
- IData  in  WIDTH_DATA_LENGTH  ROM read data, valid combinationally for IAddr.
- DataA  out  WIDTH_DATA_LENGTH  ALU operand A = R[Rd].
- DataB  out  WIDTH_DATA_LENGTH  ALU operand B = R[Rs].
- ALUSel  out  WIDTH_ALUSEL_LENGTH  ALU operation select.
- WriteCZ  out  1  ALU flag-update enable.
- DataOut  in  WIDTH_DATA_LENGTH  ALU result.
- CF  in  1  ALU carry.
- ZF  in  1  ALU zero.
- Halted  out  1  high once HLT has executed.

Behaviour:
- Clock and reset: one clock. rst is asynchronous, active-high.
- Reset values: PC=0, IR=0, Imm=0, R0..R3=0, FlagC=0, FlagZ=0, state=FETCH, ALUSel=0, WriteCZ=0, Halted=0.
- Reset mid-instruction aborts it with no register, flag or PC update.
- Instruction encoding: IR[7:4]=opcode, IR[3:2]=Rd, IR[1:0]=Rs.
  - 0x0-0x9: ALU op. ALUSel=opcode, R[Rd]<=DataOut, flags updated.
  - 0xA: LDI Rd,imm. Two bytes. R[Rd]<=imm, flags unchanged.
  - 0xB: JMP imm. Two bytes.
  - 0xC: JZ imm. Two bytes. Jumps if FlagZ=1.
  - 0xD: JC imm. Two bytes. Jumps if FlagC=1.
  - 0xE: NOP.
  - 0xF: HLT.
- FSM states FETCH, DECODE, FETCH2, EXECUTE, HALT:
  - FETCH: IR<=IData, PC<=PC+1, go to DECODE.
  - DECODE: opcode in 0xA-0xD goes to FETCH2; 0xF goes to HALT; all others go to EXECUTE.
  - FETCH2: Imm<=IData, PC<=PC+1, go to EXECUTE.
  - EXECUTE: perform the operation, go to FETCH.
  - HALT: absorbing; only rst exits it. Halted=1, PC frozen.
- ALU drive:
  - ALUSel and WriteCZ are registered.
  - Both are set on entry to EXECUTE only for opcodes 0x0-0x9: ALUSel=opcode, WriteCZ=1.
  - In every other state ALUSel holds its last value and WriteCZ=0.
  - DataA and DataB are combinational from the register file by IR fields at all times.
- EXECUTE writeback: on the edge leaving EXECUTE, R[Rd]<=DataOut and, if WriteCZ=1, FlagC<=CF and FlagZ<=ZF.
- Rd==Rs is legal: both operands read the pre-write value.
- Branch: a taken branch loads PC<=Imm at the end of EXECUTE; an untaken branch leaves PC (already past the immediate) unchanged.
- Latency:
  - 1-byte instruction: 3 cycles (FETCH, DECODE, EXECUTE).
  - 2-byte instruction: 4 cycles.
  - HLT: 2 cycles to reach HALT.
- PC arithmetic is modulo 2^WIDTH_ADDR_LENGTH: 0xFF+1 wraps to 0x00. A two-byte instruction at 0xFF takes its immediate from 0x00.
- A branch to its own address loops indefinitely; this is legal.

Optional Feature:
- Macro RETIRE_COUNT_EN.
- Defined:
  - Adds output RetireCount [15:0].
  - Reset value 0.
  - Increments by 1 on each edge leaving EXECUTE and on entry to HALT.
  - Wraps 0xFFFF to 0x0000.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset sequencing:
  - Stimulus: ROM[0]=0xA4 (LDI R1), ROM[1]=0x05. Release rst.
  - Required: R1=0x05 after 4 cycles; PC=0x02; WriteCZ stays 0 throughout.
- ALU issue:
  - Stimulus: R1=0x05, R2=0x03, then opcode 0x0 with Rd=1, Rs=2 (byte 0x06). ALU model returns DataOut=0x08, CF=0, ZF=0.
  - Required: in EXECUTE, ALUSel=0x0, WriteCZ=1, DataA=0x05, DataB=0x03. Afterwards R1=0x08, FlagC=0, FlagZ=0.
- Conditional branch:
  - Stimulus: ALU op with model ZF=1, then JZ 0x40 (0xC0, 0x40), then JC 0x80 with FlagC=0.
  - Required: PC=0x40 after JZ. JC falls through to PC=0x42.
- PC wrap:
  - Stimulus: JMP 0xFF, with ROM[0xFF]=0xA0 and ROM[0x00]=0x7E.
  - Required: R0=0x7E and PC=0x01.
- Halt and async reset:
  - Stimulus: execute HLT, then assert rst mid-cycle while in HALT.
  - Required: Halted=1 two cycles after fetching HLT. PC frozen. Async rst immediately returns all outputs to reset values, FSM to FETCH, PC=0, without waiting for a clock edge.
- RETIRE_COUNT_EN:
  - Stimulus: with the macro defined, run 3 instructions then HLT.
  - Required: RetireCount=4. With the macro undefined, the bench compiles without the port.

Source files
------------

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the
// 8-bit simple CPU. Owns PC, IR, immediate register, a 4x8 register file
// and the latched C/Z flags, and drives an external combinational ALU.
// The ALU link has no handshake: operands and select are presented for
// the whole EXECUTE cycle and DataOut/CF/ZF are consumed on the edge that
// leaves EXECUTE.
// Optional feature macro: RETIRE_COUNT_EN adds a 16-bit RetireCount
// output counting retired instructions (HLT included).
// o_dbg_state exposes the FSM state (FETCH encodes as 0).
module cpu_control_unit #(
    parameter int WIDTH_DATA_LENGTH   = 8,
    parameter int WIDTH_ALUSEL_LENGTH = 4,
    parameter int WIDTH_ADDR_LENGTH   = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [WIDTH_ADDR_LENGTH-1:0]   IAddr,
    input  logic [WIDTH_DATA_LENGTH-1:0]   IData,
    output logic [WIDTH_DATA_LENGTH-1:0]   DataA,
    output logic [WIDTH_DATA_LENGTH-1:0]   DataB,
    output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
    output logic                           WriteCZ,
    input  logic [WIDTH_DATA_LENGTH-1:0]   DataOut,
    input  logic                           CF,
    input  logic                           ZF,
    output logic                           Halted,
`ifdef RETIRE_COUNT_EN
    output logic [15:0]                    RetireCount,
`endif
    output logic [2:0]                     o_dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_FETCH2  = 3'd2,
        S_EXECUTE = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    localparam logic [WIDTH_ADDR_LENGTH-1:0] PC_ONE = 1;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [WIDTH_ADDR_LENGTH-1:0]     r_pc;
    logic [WIDTH_DATA_LENGTH-1:0]     r_ir;
    logic [WIDTH_DATA_LENGTH-1:0]     r_imm;
    logic [WIDTH_DATA_LENGTH-1:0]     r_regs [4];
    logic                             r_flag_c;
    logic                             r_flag_z;
    logic [WIDTH_ALUSEL_LENGTH-1:0]   r_alusel;
    logic                             r_writecz;

    logic [3:0] w_opcode;
    logic [1:0] w_rd;
    logic [1:0] w_rs;
    logic       w_is_alu_op;
    logic       w_take_branch;
    logic       w_ir_load;
    logic       w_imm_load;
    logic       w_pc_inc;
    logic       w_exec;
    logic       w_alu_issue;
    logic       w_halt_enter;

    assign w_opcode    = r_ir[7:4];
    assign w_rd        = r_ir[3:2];
    assign w_rs        = r_ir[1:0];
    assign w_is_alu_op = (w_opcode <= 4'd9);

    // Branch condition evaluated against flags latched by earlier ALU ops.
    assign w_take_branch = (w_opcode == 4'hB) ||
                           ((w_opcode == 4'hC) && r_flag_z) ||
                           ((w_opcode == 4'hD) && r_flag_c);

    assign IAddr       = r_pc;
    assign DataA       = r_regs[w_rd];
    assign DataB       = r_regs[w_rs];
    assign ALUSel      = r_alusel;
    assign WriteCZ     = r_writecz;
    assign Halted      = (r_state == S_HALT);
    assign o_dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_state_nxt;
    end

    // Next-state decode and per-state datapath strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_ir_load    = 1'b0;
        w_imm_load   = 1'b0;
        w_pc_inc     = 1'b0;
        w_exec       = 1'b0;
        w_alu_issue  = 1'b0;
        w_halt_enter = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_load   = 1'b1;
                w_pc_inc    = 1'b1;
                w_state_nxt = S_DECODE;
            end
            S_DECODE: begin
                if ((w_opcode >= 4'hA) && (w_opcode <= 4'hD)) begin
                    w_state_nxt = S_FETCH2;
                end else if (w_opcode == 4'hF) begin
                    w_state_nxt  = S_HALT;
                    w_halt_enter = 1'b1;
                end else begin
                    w_state_nxt = S_EXECUTE;
                    w_alu_issue = w_is_alu_op;
                end
            end
            S_FETCH2: begin
                w_imm_load  = 1'b1;
                w_pc_inc    = 1'b1;
                w_state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_exec      = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_HALT: begin
                w_state_nxt = S_HALT;
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // Program counter: sequential increment, or branch target at end of EXECUTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= '0;
        end else if (w_exec && w_take_branch) begin
            r_pc <= r_imm[WIDTH_ADDR_LENGTH-1:0];
        end else if (w_pc_inc) begin
            r_pc <= r_pc + PC_ONE;
        end
    end

    // Instruction and immediate capture from the ROM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir  <= '0;
            r_imm <= '0;
        end else begin
            if (w_ir_load)  r_ir  <= IData;
            if (w_imm_load) r_imm <= IData;
        end
    end

    // Register file writeback on the edge leaving EXECUTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else if (w_exec) begin
            if (w_is_alu_op)            r_regs[w_rd] <= DataOut;
            else if (w_opcode == 4'hA)  r_regs[w_rd] <= r_imm;
        end
    end

    // Flags follow the ALU only when the flag-update enable was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (w_exec && r_writecz) begin
            r_flag_c <= CF;
            r_flag_z <= ZF;
        end
    end

    // ALU select/enable: loaded on entry to EXECUTE for ALU ops; select
    // otherwise holds, enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alusel  <= '0;
            r_writecz <= 1'b0;
        end else begin
            r_writecz <= w_alu_issue;
            if (w_alu_issue) r_alusel <= w_opcode;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic [15:0] r_retire;

    // Retired-instruction counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_retire <= 16'd0;
        else if (w_exec || w_halt_enter) r_retire <= r_retire + 16'd1;
    end

    assign RetireCount = r_retire;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: instruction-level model emits the expected
// per-cycle output trace; a bench ALU answers the DUT's requests.
`timescale 1ns/1ps
module tb_cpu_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] IAddr, IData, DataA, DataB, DataOut;
    logic [3:0] ALUSel;
    logic       WriteCZ, CF, ZF, Halted;
    logic [2:0] dbg_state;
`ifdef RETIRE_COUNT_EN
    logic [15:0] RetireCount;
`endif

    logic [7:0]  rom [256];
    logic [8:0]  alu_w;
    logic [45:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // model state
    logic [7:0]  m_pc, m_ir, m_imm;
    logic [7:0]  m_r [4];
    logic        m_fc, m_fz;
    logic [3:0]  m_sel;
    logic [15:0] m_rc;

    cpu_control_unit dut (
        .clk(clk), .rst(rst), .IAddr(IAddr), .IData(IData),
        .DataA(DataA), .DataB(DataB), .ALUSel(ALUSel), .WriteCZ(WriteCZ),
        .DataOut(DataOut), .CF(CF), .ZF(ZF), .Halted(Halted),
`ifdef RETIRE_COUNT_EN
        .RetireCount(RetireCount),
`endif
        .o_dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // asynchronous ROM
    assign IData = rom[IAddr];

    // bench ALU: {carry, result}
    function automatic logic [8:0] alu_f(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b);
        case (sel)
            4'd0:    return {1'b0, a} + {1'b0, b};
            4'd1:    return {1'b0, a} - {1'b0, b};
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            4'd5:    return {1'b0, ~a};
            4'd6:    return {a, 1'b0};
            4'd7:    return {a[0], 1'b0, a[7:1]};
            4'd8:    return {1'b0, a} + 9'd1;
            default: return {1'b0, a} - 9'd1;
        endcase
    endfunction

    assign alu_w   = alu_f(ALUSel, DataA, DataB);
    assign DataOut = alu_w[7:0];
    assign CF      = alu_w[8];
    assign ZF      = (alu_w[7:0] == 8'h00);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // expected record: {rc, halted, writecz, alusel, dataB, dataA, iaddr}
    task automatic emit(input logic [7:0] addr, input logic wcz, input logic hlt);
        exp_q.push_back({m_rc, hlt, wcz, m_sel, m_r[m_ir[1:0]], m_r[m_ir[3:2]], addr});
    endtask

    // instruction-level model producing one record per clock cycle
    task automatic iss_run(input int n_instr);
        logic [3:0] op;
        logic [1:0] rd, rs;
        logic [8:0] res;
        m_pc = 0; m_ir = 0; m_imm = 0; m_fc = 0; m_fz = 0; m_sel = 0; m_rc = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        exp_q.delete();
        for (int n = 0; n < n_instr; n++) begin
            emit(m_pc, 1'b0, 1'b0);
            m_ir = rom[m_pc];
            m_pc++;
            op = m_ir[7:4]; rd = m_ir[3:2]; rs = m_ir[1:0];
            emit(m_pc, 1'b0, 1'b0);
            if (op == 4'hF) begin
                m_rc++;
                repeat (3) emit(m_pc, 1'b0, 1'b1);
                return;
            end
            if (op >= 4'hA && op <= 4'hD) begin
                emit(m_pc, 1'b0, 1'b0);
                m_imm = rom[m_pc];
                m_pc++;
                emit(m_pc, 1'b0, 1'b0);
                case (op)
                    4'hA: m_r[rd] = m_imm;
                    4'hB: m_pc = m_imm;
                    4'hC: if (m_fz) m_pc = m_imm;
                    4'hD: if (m_fc) m_pc = m_imm;
                    default: ;
                endcase
            end else if (op <= 4'd9) begin
                m_sel = op;
                emit(m_pc, 1'b1, 1'b0);
                res = alu_f(op, m_r[rd], m_r[rs]);
                m_r[rd] = res[7:0];
                m_fc = res[8];
                m_fz = (res[7:0] == 8'h00);
            end else begin
                emit(m_pc, 1'b0, 1'b0);
            end
            m_rc++;
        end
    endtask

    task automatic check_rec(input logic [45:0] r);
        check("IAddr",   16'(IAddr),   16'(r[7:0]));
        check("DataA",   16'(DataA),   16'(r[15:8]));
        check("DataB",   16'(DataB),   16'(r[23:16]));
        check("ALUSel",  16'(ALUSel),  16'(r[27:24]));
        check("WriteCZ", 16'(WriteCZ), 16'(r[28]));
        check("Halted",  16'(Halted),  16'(r[29]));
`ifdef RETIRE_COUNT_EN
        check("RetireCount", RetireCount, r[45:30]);
`endif
    endtask

    task automatic start_prog();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    endtask

    // reset, release at a falling edge, then compare every cycle of the trace
    task automatic run_prog(input int n_instr);
        logic [45:0] rec;
        iss_run(n_instr);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            rec = exp_q.pop_front();
            check_rec(rec);
            if (exp_q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        // reset state
        start_prog();
        repeat (2) @(negedge clk);
        check("rst IAddr",   16'(IAddr),   16'h0000);
        check("rst ALUSel",  16'(ALUSel),  16'h0000);
        check("rst WriteCZ", 16'(WriteCZ), 16'h0000);
        check("rst Halted",  16'(Halted),  16'h0000);
        check("rst DataA",   16'(DataA),   16'h0000);

        // reset sequencing: LDI R1,5 ; NOP (shows R1,R2) ; HLT
        start_prog();
        rom[0] = 8'hA4; rom[1] = 8'h05; rom[2] = 8'hE6; rom[3] = 8'hF0;
        run_prog(10);
        check("P1 model R1", 16'(m_r[1]), 16'h0005);
        check("P1 halt IAddr", 16'(IAddr), 16'h0004);

        // ALU issue: ADD R1,R2 ; SUB R2,R1 ; ADD R1,R1 ; HLT (shows R1,R2)
        start_prog();
        rom[0] = 8'hA4; rom[1] = 8'h05; rom[2] = 8'hA8; rom[3] = 8'h03;
        rom[4] = 8'h06; rom[5] = 8'h19; rom[6] = 8'h05; rom[7] = 8'hF6;
        run_prog(10);
        check("P2 model R1", 16'(m_r[1]), 16'h0010);
        check("P2 model R2", 16'(m_r[2]), 16'h00FB);
        check("P2 DataA R1", 16'(DataA), 16'h0010);
        check("P2 DataB R2", 16'(DataB), 16'h00FB);

        // conditional branch: SUB R1,R1 (Z=1) ; JZ 0x40 ; JC 0x80 falls through
        start_prog();
        rom[0] = 8'hA4; rom[1] = 8'h05; rom[2] = 8'h15; rom[3] = 8'hC0; rom[4] = 8'h40;
        rom[8'h40] = 8'hD0; rom[8'h41] = 8'h80; rom[8'h42] = 8'hF0;
        run_prog(10);
        check("P3 model PC", 16'(m_pc), 16'h0043);
        check("P3 halt IAddr", 16'(IAddr), 16'h0043);
        check("P3 Halted", 16'(Halted), 16'h0001);

        // PC wrap: op at 0 doubles as LDI immediate; JMP 0xFF ; LDI R0 at 0xFF
        start_prog();
        rom[0] = 8'h7E; rom[1] = 8'hB0; rom[2] = 8'hFF; rom[8'hFF] = 8'hA0;
        run_prog(3);
        check("P4 model R0", 16'(m_r[0]), 16'h007E);
        check("P4 model PC", 16'(m_pc), 16'h0001);
        @(negedge clk);
        check("P4 IAddr after wrap", 16'(IAddr), 16'h0001);
        check("P4 DataA R0", 16'(DataA), 16'h007E);

        // halt then asynchronous reset mid-cycle
        start_prog();
        rom[0] = 8'hA4; rom[1] = 8'h05; rom[2] = 8'h36; rom[3] = 8'hF4;
        run_prog(10);
        check("P5 halt ALUSel", 16'(ALUSel), 16'h0003);
        check("P5 halt DataA", 16'(DataA), 16'h0005);
        #2 rst = 1'b1;
        #1;
        check("arst IAddr",   16'(IAddr),     16'h0000);
        check("arst Halted",  16'(Halted),    16'h0000);
        check("arst ALUSel",  16'(ALUSel),    16'h0000);
        check("arst WriteCZ", 16'(WriteCZ),   16'h0000);
        check("arst DataA",   16'(DataA),     16'h0000);
        check("arst state",   16'(dbg_state), 16'h0000);

        // retire count: NOP ; NOP ; LDI ; HLT
        start_prog();
        rom[0] = 8'hE0; rom[1] = 8'hE0; rom[2] = 8'hA4; rom[3] = 8'h05; rom[4] = 8'hF0;
        run_prog(10);
        check("P6 model retire", m_rc, 16'd4);
`ifdef RETIRE_COUNT_EN
        check("P6 RetireCount", RetireCount, 16'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
